// File: rtl/data_memory_lsu_if.sv
// Request/response bundle between the core's MEM stage (master) and the
// data-memory load/store unit (slave).
interface data_memory_lsu_if #(
    parameter int A = 32
);
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [A-1:0] req_addr;
    logic [2:0]   req_size;
    logic [31:0]  req_wdata;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_memory_lsu.sv
// Byte-addressed RISC-V data memory: one request in flight, sized loads/stores,
// fault detection at acceptance and a configurable number of wait states.
module data_memory_lsu #(
    parameter int A           = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    data_memory_lsu_if.slave bus
);
    localparam int           AW    = $clog2(DEPTH);
    localparam logic [A-1:0] LIMIT = A'(DEPTH);
    localparam logic [3:0]   WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_fault(input logic [A-1:0] addr, input logic [2:0] size,
                                      input logic we);
        logic f;
        case (size)
            3'd0:    f = 1'b0;
            3'd1:    f = addr[0];
            3'd2:    f = |addr[1:0];
            3'd4:    f = we;
            3'd5:    f = we | addr[0];
            default: f = 1'b1;
        endcase
        if ({2'b00, addr[A-1:2]} >= LIMIT) begin
            f = 1'b1;
        end else begin
            f = f;
        end
        return f;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] size);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (size)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd2:    r = word;
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] off, input logic [2:0] size);
        logic [3:0] be;
        case (size)
            3'd0:    be = 4'b0001 << off;
            3'd1:    be = off[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] wd, input logic [2:0] size);
        logic [31:0] l;
        case (size)
            3'd0:    l = {4{wd[7:0]}};
            3'd1:    l = {2{wd[15:0]}};
            default: l = wd;
        endcase
        return l;
    endfunction

    logic [31:0]  mem_r [DEPTH];
    state_t       state_r;
    logic [3:0]   cnt_r;
    logic         ready_r;
    logic         resp_valid_r;
    logic [31:0]  resp_rdata_r;
    logic         resp_err_r;
    logic         we_r;
    logic [A-1:0] addr_r;
    logic [2:0]   size_r;

    logic         hs_s;
    logic         cur_we_s;
    logic [A-1:0] cur_addr_s;
    logic [2:0]   cur_size_s;
    logic         fault_s;
    logic [31:0]  rd_word_s;
    logic [31:0]  load_s;
    logic [3:0]   be_s;
    logic [31:0]  wlane_s;

    assign hs_s = bus.req_valid && ready_r;

    // Live request fields in IDLE, captured ones afterwards; derive fault and load result.
    always_comb begin
        if (state_r == IDLE) begin
            cur_we_s   = bus.req_we;
            cur_addr_s = bus.req_addr;
            cur_size_s = bus.req_size;
        end else begin
            cur_we_s   = we_r;
            cur_addr_s = addr_r;
            cur_size_s = size_r;
        end
        fault_s   = is_fault(cur_addr_s, cur_size_s, cur_we_s);
        rd_word_s = mem_r[cur_addr_s[AW+1:2]];
        if (fault_s || cur_we_s) begin
            load_s = 32'd0;
        end else begin
            load_s = load_ext(rd_word_s, cur_addr_s[1:0], cur_size_s);
        end
        be_s    = byte_en(bus.req_addr[1:0], bus.req_size);
        wlane_s = lanes(bus.req_wdata, bus.req_size);
    end

    // Storage array: stores commit on the acceptance edge, contents are never reset.
    always_ff @(posedge clk) begin
        if (hs_s && bus.req_we && !fault_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[bus.req_addr[AW+1:2]][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            ready_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= '0;
            size_r       <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_valid_r <= 1'b0;
                    if (hs_s) begin
                        we_r    <= bus.req_we;
                        addr_r  <= bus.req_addr;
                        size_r  <= bus.req_size;
                        ready_r <= 1'b0;
                        cnt_r   <= 4'd0;
                        if (WAIT_STATES == 0) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= load_s;
                            resp_err_r   <= fault_s;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_r == WS_M1) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= load_s;
                        resp_err_r   <= fault_s;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                RESP: begin
                    resp_valid_r <= 1'b0;
                    ready_r      <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b0;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: two instances (0 and 3 wait states) checked every
// cycle against a byte-level memory model, plus hand-computed literal results.
module tb_data_memory_lsu;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    int          sel;

    always #5 clk = ~clk;

    data_memory_lsu_if #(.A(32)) if0 ();
    data_memory_lsu_if #(.A(32)) if3 ();

    assign if0.req_valid = req_valid && (sel == 0);
    assign if0.req_we    = req_we;
    assign if0.req_addr  = req_addr;
    assign if0.req_size  = req_size;
    assign if0.req_wdata = req_wdata;
    assign if3.req_valid = req_valid && (sel == 1);
    assign if3.req_we    = req_we;
    assign if3.req_addr  = req_addr;
    assign if3.req_size  = req_size;
    assign if3.req_wdata = req_wdata;

    data_memory_lsu #(.A(32), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    data_memory_lsu #(.A(32), .DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave));

    logic [1:0]  rdy, rvl, rer, vin;
    logic [31:0] rdt [2];
    assign rdy[0] = if0.req_ready;  assign rdy[1] = if3.req_ready;
    assign rvl[0] = if0.resp_valid; assign rvl[1] = if3.resp_valid;
    assign rer[0] = if0.resp_err;   assign rer[1] = if3.resp_err;
    assign rdt[0] = if0.resp_rdata; assign rdt[1] = if3.resp_rdata;
    assign vin[0] = if0.req_valid;  assign vin[1] = if3.req_valid;

    int checks = 0, failures = 0, cyc = 0;
    int ws [2] = '{0, 3};

    // literal expectations supplied by the driver for the next handshake
    logic        lit_on = 1'b0, lit_err = 1'b0;
    logic [31:0] lit_rd = 32'd0;
    int          lit_lat = 0, lit_gap = 0;

    int          rem [2] = '{0, 0};
    int          post [2] = '{1, 1};
    int          hs_c [2] = '{0, 0};
    int          rsp_c [2] = '{0, 0};
    int          drop_c [2] = '{0, 0};
    int          hs_cyc [2] = '{0, 0};
    int          last_hs [2] = '{-1000, -1000};
    logic [31:0] e_rd [2];
    logic        e_err [2];
    logic        p_lon [2];
    logic [31:0] p_lrd [2];
    logic        p_lerr [2];
    int          p_llat [2];
    logic        fin_req = 1'b0, fin_done = 1'b0;

    logic [7:0]  mb [longint];

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL dut%0d %s: got 0x%08h expected 0x%08h (cycle %0d)", d, nm, act, exp, cyc);
        end
    endtask

    // Spec-level model: memory as individual bytes, loads assembled and extended arithmetically.
    task automatic model_req(input int i, input logic we, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int          n;
        longint      k;
        logic [31:0] v;
        n   = (s[1:0] == 2'd0) ? 1 : ((s[1:0] == 2'd1) ? 2 : 4);
        err = !(s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && s[2]) ||
              ((a % n) != 0) || ((a / 4) >= DEPTH);
        rd  = 32'd0;
        v   = 32'd0;
        if (!err) begin
            for (int b = 0; b < n; b++) begin
                k = longint'(i) * 64'h1_0000_0000 + longint'(a) + longint'(b);
                if (we) mb[k] = wd[8*b +: 8];
                else v[8*b +: 8] = mb.exists(k) ? mb[k] : 8'h00;
            end
            if (!we) begin
                if (!s[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                rd = v;
            end
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] trd;
        logic        terr;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk(i, "reset_ready", 32'(rdy[i]), 32'd0);
                chk(i, "reset_valid", 32'(rvl[i]), 32'd0);
                if (rem[i] > 0) drop_c[i]++;
                rem[i]  = 0;
                post[i] = 1;
            end else if (rem[i] > 0) begin
                chk(i, "busy_ready", 32'(rdy[i]), 32'd0);
                chk(i, "resp_valid", 32'(rvl[i]), 32'(rem[i] == 1));
                if (rem[i] == 1) begin
                    chk(i, "resp_rdata", rdt[i], e_rd[i]);
                    chk(i, "resp_err", 32'(rer[i]), 32'(e_err[i]));
                    if (p_lon[i]) begin
                        chk(i, "lit_rdata", rdt[i], p_lrd[i]);
                        chk(i, "lit_err", 32'(rer[i]), 32'(p_lerr[i]));
                        chk(i, "lit_latency", 32'(cyc - hs_cyc[i]), 32'(p_llat[i]));
                    end
                end
                rem[i]--;
            end else begin
                chk(i, "idle_ready", 32'(rdy[i]), (post[i] != 0) ? 32'd0 : 32'd1);
                chk(i, "idle_valid", 32'(rvl[i]), 32'd0);
                post[i] = 0;
                if (vin[i] && rdy[i]) begin
                    model_req(i, req_we, req_addr, req_size, req_wdata, trd, terr);
                    e_rd[i]  = trd;
                    e_err[i] = terr;
                    rem[i]   = 1 + ws[i];
                    hs_c[i]++;
                    if (lit_gap > 0) chk(i, "lit_gap", 32'(cyc - last_hs[i]), 32'(lit_gap));
                    last_hs[i] = cyc;
                    hs_cyc[i]  = cyc;
                    p_lon[i]   = lit_on;
                    p_lrd[i]   = lit_rd;
                    p_lerr[i]  = lit_err;
                    p_llat[i]  = lit_lat;
                end
            end
            if (rvl[i]) rsp_c[i]++;
        end
        if (fin_req && !fin_done) begin
            for (int i = 0; i < 2; i++)
                chk(i, "resp_count", 32'(rsp_c[i]), 32'(hs_c[i] - drop_c[i]));
            chk(1, "dropped_by_reset", 32'(drop_c[1]), 32'd2);
            fin_done = 1'b1;
        end
    end

    task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd,
                         input logic lon, input logic [31:0] lrd, input logic lerr, input int llat,
                         input int lgap);
        int n;
        req_we = we; req_addr = a; req_size = s; req_wdata = wd;
        lit_on = lon; lit_rd = lrd; lit_err = lerr; lit_lat = llat; lit_gap = lgap;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[sel] && n < 60);
        if (!rdy[sel]) begin
            $display("FAIL dut%0d handshake_timeout: got ready=0 expected ready=1 within 60 cycles", sel);
            $fatal(1, "handshake timeout");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tx(input logic we, input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd,
                      input logic [31:0] rd, input logic err);
        issue(we, a, s, wd, 1'b1, rd, err, (sel == 0) ? 1 : 4, 0);
        idle(6);
    endtask

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_size = 3'd0;
        req_wdata = 32'd0; sel = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // zero wait states: basic word store/load
        sel = 0;
        tx(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0);
        tx(1'b0, 32'h10, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0);
        // byte and half lanes
        tx(1'b1, 32'h20, 3'd2, 32'h00000000, 32'h0, 1'b0);
        tx(1'b1, 32'h21, 3'd0, 32'h00000080, 32'h0, 1'b0);
        tx(1'b1, 32'h22, 3'd1, 32'h0000ABCD, 32'h0, 1'b0);
        tx(1'b0, 32'h20, 3'd2, 32'h0, 32'hABCD8000, 1'b0);
        tx(1'b0, 32'h21, 3'd0, 32'h0, 32'hFFFFFF80, 1'b0);
        tx(1'b0, 32'h21, 3'd4, 32'h0, 32'h00000080, 1'b0);
        tx(1'b0, 32'h22, 3'd1, 32'h0, 32'hFFFFABCD, 1'b0);
        tx(1'b0, 32'h22, 3'd5, 32'h0, 32'h0000ABCD, 1'b0);
        tx(1'b0, 32'h23, 3'd0, 32'h0, 32'hFFFFFFAB, 1'b0);
        // faults
        tx(1'b0, 32'h13, 3'd2, 32'h0, 32'h0, 1'b1);
        tx(1'b1, 32'h04, 3'd2, 32'h11223344, 32'h0, 1'b0);
        tx(1'b1, 32'h05, 3'd1, 32'h0000FFFF, 32'h0, 1'b1);
        tx(1'b0, 32'h04, 3'd2, 32'h0, 32'h11223344, 1'b0);
        tx(1'b0, 32'h1000, 3'd2, 32'h0, 32'h0, 1'b1);
        tx(1'b0, 32'hFFFFFFFC, 3'd2, 32'h0, 32'h0, 1'b1);
        tx(1'b0, 32'h10, 3'd3, 32'h0, 32'h0, 1'b1);
        tx(1'b1, 32'h30, 3'd4, 32'h55, 32'h0, 1'b1);
        tx(1'b0, 32'h0FFC, 3'd2, 32'h0, 32'h0, 1'b0);

        // three wait states: latency and held-request throughput
        sel = 1;
        tx(1'b1, 32'h40, 3'd2, 32'h12345678, 32'h0, 1'b0);
        issue(1'b0, 32'h40, 3'd2, 32'h0, 1'b1, 32'h12345678, 1'b0, 4, 0);
        issue(1'b0, 32'h40, 3'd2, 32'h0, 1'b1, 32'h12345678, 1'b0, 4, 5);
        idle(6);

        // reset during the wait of a store, then during the wait of a load
        issue(1'b1, 32'h44, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 0, 0);
        req_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        issue(1'b0, 32'h40, 3'd2, 32'h0, 1'b0, 32'h0, 1'b0, 0, 0);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        tx(1'b0, 32'h44, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0);
        tx(1'b0, 32'h40, 3'd2, 32'h0, 32'h12345678, 1'b0);

        // back-to-back alternating SW/LW with req_valid held high
        for (int d = 0; d < 2; d++) begin
            sel = d;
            for (int k = 0; k < 4; k++) begin
                issue(1'b1, 32'h100 + 32'(4 * k), 3'd2, {8'hA5, 8'(k), 16'h5A5A},
                      1'b1, 32'h0, 1'b0, (d == 0) ? 1 : 4, (k > 0) ? ((d == 0) ? 2 : 5) : 0);
                issue(1'b0, 32'h100 + 32'(4 * k), 3'd2, 32'h0,
                      1'b1, {8'hA5, 8'(k), 16'h5A5A}, 1'b0, (d == 0) ? 1 : 4, (d == 0) ? 2 : 5);
            end
            idle(6);
        end

        fin_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Byte-addressed RISC-V data memory with a request/response handshake, sized accesses and fault detection.
- Supports LB/LH/LW/LBU/LHU and SB/SH/SW, with byte-lane writes and sign/zero-extended loads.
- Configurable wait states model slower memory.
- Sits between the core's MEM stage and the word-organised storage array, and holds at most one request in flight.

Parameters:
- A, 32, byte-address width.
- DEPTH, 1024, number of 32-bit words (4 KiB default); must be a power of two.
- WAIT_STATES, 0, extra cycles between acceptance and response (0..15).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1=store, 0=load.
- req_addr  in  A  byte address.
- req_size  in  3  RISC-V funct3: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- req_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- resp_valid  out  1  one-cycle pulse; response present.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  request faulted; qualified by resp_valid.

Behaviour:
- Reset values (while rst_n=0): state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Array contents are not reset and are undefined until written.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. Handshake when req_valid&&req_ready. Next state is WAIT if WAIT_STATES>0, else RESP.
  - WAIT: req_ready=0. Counter counts WAIT_STATES cycles, then goes to RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0. Returns to IDLE.
- Latency: the handshake at edge k gives resp_valid high during cycle k+1+WAIT_STATES. Throughput is one request per 2+WAIT_STATES cycles. The response cannot be back-pressured.
- Fault checks are evaluated at acceptance. resp_err=1, no array write and resp_rdata=0 when any of the following holds:
  - Misaligned: size H/HU with addr[0]=1, or size W with addr[1:0]!=0.
  - Out of range: addr[A-1:2] >= DEPTH.
  - Illegal size: 3, 6 or 7; or a store with size 4 or 5.
- Stores:
  - The array is written on the acceptance edge, with byte enables derived from size and addr[1:0].
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes are preserved.
- Loads:
  - The word is read at word index addr[A-1:2].
  - Request fields are registered at acceptance.
  - The array word is sampled on the edge entering RESP.
  - The byte/half is selected by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- resp_rdata and resp_err hold their last values outside RESP; the bench must qualify them with resp_valid.
- A load issued immediately after a store to the same word returns the updated data, because the store commits before the next acceptance.
- Reset mid-operation:
  - rst_n low in WAIT or RESP forces IDLE immediately and suppresses resp_valid.
  - A store already accepted remains committed.
  - An accepted load is dropped without a response.
- Request inputs are ignored while req_ready=0. The requester must hold req_valid and fields stable until the handshake.

Test Plan:
- WAIT_STATES=0: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_valid exactly 1 cycle after each handshake; load resp_rdata=0xDEADBEEF, resp_err=0; store resp_rdata=0.
- Byte/half lanes: SW 0x20 0x00000000; SB 0x21 0x80; SH 0x22 0xABCD -> LW 0x20 returns 0xABCD8000. LB 0x21 returns 0xFFFFFF80, LBU 0x21 returns 0x00000080, LH 0x22 returns 0xFFFFABCD, LHU 0x22 returns 0x0000ABCD.
- Faults:
  - LW 0x13 -> resp_err=1, resp_rdata=0.
  - SH 0x05 -> resp_err=1, and a subsequent LW 0x04 shows unchanged data.
  - LW at 4*DEPTH -> resp_err=1.
  - Load with req_size=3 -> resp_err=1.
- WAIT_STATES=3: LW handshake at cycle 0 -> resp_valid in cycle 4 only; req_ready=0 in cycles 1-4; a req_valid held during that window is accepted in cycle 5.
- Reset: assert rst_n=0 during the WAIT of an LW -> no resp_valid, req_ready=0 while in reset and 1 the cycle after release. A store accepted before the reset is readable afterwards.
- Back-to-back: req_valid held high with 8 alternating SW/LW to consecutive words -> every LW returns the preceding SW data, one response per request, no response lost or duplicated.
